// File: rtl/byte_op_if.sv
// Handshake and datapath bundle between byte_op_ctrl, its requester, the register file
// and the byte-manipulation unit.
interface byte_op_if #(
    parameter int RA_W = 3
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [RA_W-1:0] req_dst;
    logic [7:0]      req_byte;
    logic [RA_W-1:0] rf_rd_addr;
    logic [15:0]     rf_rd_data;
    logic [2:0]      bm_op;
    logic [7:0]      bm_byte;
    logic [15:0]     bm_dst_in;
    logic            bm_E;
    logic [15:0]     bm_dst_out;
    logic            rf_wr_en;
    logic [RA_W-1:0] rf_wr_addr;
    logic [15:0]     rf_wr_data;
    logic            done;
    logic            err;

    modport master (
        input  req_valid, req_op, req_dst, req_byte, rf_rd_data, bm_dst_out,
        output req_ready, rf_rd_addr, bm_op, bm_byte, bm_dst_in, bm_E,
               rf_wr_en, rf_wr_addr, rf_wr_data, done, err
    );

    modport slave (
        output req_valid, req_op, req_dst, req_byte, rf_rd_data, bm_dst_out,
        input  req_ready, rf_rd_addr, bm_op, bm_byte, bm_dst_in, bm_E,
               rf_wr_en, rf_wr_addr, rf_wr_data, done, err
    );
endinterface

// File: rtl/byte_op_ctrl.sv
// Sequencer for byte ops: read dst, strobe the byte-manipulation unit, write the result back.
// Optional BYTE_OP_CTRL_FWD_EN: reuse the last written value and skip the register read.
module byte_op_ctrl #(
    parameter int BM_LAT = 1,
    parameter int RA_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    byte_op_if.master   bus
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WAIT, WRITE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(BM_LAT - 1);

    state_t          state;
    logic [2:0]      cnt;
    logic [2:0]      op_q;
    logic [RA_W-1:0] dst_q;
    logic [7:0]      byte_q;
    logic            req_ready_q;
    logic [RA_W-1:0] rd_addr_q;
    logic [2:0]      bm_op_q;
    logic [7:0]      bm_byte_q;
    logic [15:0]     bm_dst_in_q;
    logic            bm_e_q;
    logic            wr_en_q;
    logic [RA_W-1:0] wr_addr_q;
    logic [15:0]     wr_data_q;
    logic            done_q;
    logic            err_q;
`ifdef BYTE_OP_CTRL_FWD_EN
    logic            lw_valid;
    logic [RA_W-1:0] lw_addr;
    logic [15:0]     lw_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            dst_q       <= '0;
            byte_q      <= '0;
            req_ready_q <= 1'b1;
            rd_addr_q   <= '0;
            bm_op_q     <= '0;
            bm_byte_q   <= '0;
            bm_dst_in_q <= '0;
            bm_e_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BYTE_OP_CTRL_FWD_EN
            lw_valid    <= 1'b0;
            lw_addr     <= '0;
            lw_data     <= '0;
`endif
        end else begin
            bm_e_q  <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        op_q   <= bus.req_op;
                        dst_q  <= bus.req_dst;
                        byte_q <= bus.req_byte;
                        if (bus.req_op > 3'd4) begin
                            err_q <= 1'b1;
                        end else begin
                            req_ready_q <= 1'b0;
`ifdef BYTE_OP_CTRL_FWD_EN
                            // dst was just written: its value is already held here
                            if (lw_valid && lw_addr == bus.req_dst) begin
                                bm_op_q     <= bus.req_op;
                                bm_byte_q   <= bus.req_byte;
                                bm_dst_in_q <= lw_data;
                                bm_e_q      <= 1'b1;
                                state       <= EXEC;
                            end else
`endif
                            begin
                                rd_addr_q <= bus.req_dst;
                                state     <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    bm_op_q     <= op_q;
                    bm_byte_q   <= byte_q;
                    bm_dst_in_q <= bus.rf_rd_data;
                    bm_e_q      <= 1'b1;
                    state       <= EXEC;
                end
                EXEC: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= dst_q;
                        wr_data_q <= bus.bm_dst_out;
                        done_q    <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WRITE: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
`ifdef BYTE_OP_CTRL_FWD_EN
                    lw_valid    <= 1'b1;
                    lw_addr     <= wr_addr_q;
                    lw_data     <= wr_data_q;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rf_rd_addr = rd_addr_q;
    assign bus.bm_op      = bm_op_q;
    assign bus.bm_byte    = bm_byte_q;
    assign bus.bm_dst_in  = bm_dst_in_q;
    assign bus.bm_E       = bm_e_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_wr_data = wr_data_q;
    assign bus.err        = err_q;
    // Reset arriving in the WRITE cycle must still suppress the register-file write.
    assign bus.rf_wr_en   = wr_en_q & rst_n;
    assign bus.done       = done_q & rst_n;
endmodule

// File: tb/tb_byte_op_ctrl.sv
// Randomized bench for byte_op_ctrl: register file and byte unit models plus a
// transaction-level reference of expected results and timing.
module tb_byte_op_ctrl;
    localparam int BM_LAT = 3;
    localparam int RA_W   = 3;
`ifdef BYTE_OP_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    byte_op_if #(.RA_W(RA_W)) bus();

    byte_op_ctrl #(.BM_LAT(BM_LAT), .RA_W(RA_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bm_f(input logic [2:0] op, input logic [7:0] b,
                                         input logic [15:0] d);
        case (op)
            3'd0:    return {d[15:8], b};
            3'd1:    return {8'h00, b};
            3'd2:    return {{8{b[7]}}, b};
            3'd3:    return {b, d[7:0]};
            3'd4:    return {d[7:0], d[15:8]};
            default: return d;
        endcase
    endfunction

    // register file: combinational read, written by the DUT or by the bench preload
    logic [15:0] rf [8];
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    assign bus.rf_rd_data = rf[bus.rf_rd_addr];
    always @(posedge clk) begin
        if (ld_en) rf[ld_addr] <= ld_data;
        else if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
    end

    // byte unit: garbage until BM_LAT edges after the strobe, then the result
    int          bm_cnt = 0;
    logic [15:0] bm_pend = '0;
    always @(posedge clk) begin
        if (bus.bm_E) begin
            if (BM_LAT == 1) bus.bm_dst_out <= bm_f(bus.bm_op, bus.bm_byte, bus.bm_dst_in);
            else begin
                bus.bm_dst_out <= 16'($urandom);
                bm_pend        <= bm_f(bus.bm_op, bus.bm_byte, bus.bm_dst_in);
                bm_cnt         <= BM_LAT - 1;
            end
        end else if (bm_cnt > 0) begin
            bm_cnt <= bm_cnt - 1;
            if (bm_cnt == 1) bus.bm_dst_out <= bm_pend;
        end
    end

    // reference state
    logic [15:0] m_rf [8];
    bit          m_lw_vld = 1'b0;
    logic [2:0]  m_lw_addr = '0;

    task automatic drive_junk();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_op    = 3'($urandom);
        bus.req_dst   = 3'($urandom);
        bus.req_byte  = 8'($urandom);
    endtask

    // legal op, entered and left at a negedge in IDLE
    task automatic txn(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] b);
        bit hit;
        int lat, e_cyc, wr_cyc, n_bm, n_wr, n_rdy_lo, n_dn_bad;
        logic [15:0] old, exp, bm_in_s, wr_d;
        logic [2:0]  bm_op_s, wr_a, rd_a;
        logic [7:0]  bm_b_s;
        hit = FWD && m_lw_vld && (m_lw_addr == dst);
        lat = hit ? 2 + BM_LAT : 3 + BM_LAT;
        old = m_rf[dst];
        exp = bm_f(op, b, old);
        e_cyc = -1; wr_cyc = -1; n_bm = 0; n_wr = 0; n_rdy_lo = 0; n_dn_bad = 0;
        bm_in_s = 'x; bm_op_s = 'x; bm_b_s = 'x; wr_a = 'x; wr_d = 'x; rd_a = 'x;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_dst = dst; bus.req_byte = b;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (bus.bm_E) begin
                n_bm++; e_cyc = k;
                bm_in_s = bus.bm_dst_in; bm_op_s = bus.bm_op; bm_b_s = bus.bm_byte;
            end
            if (bus.rf_wr_en) begin
                n_wr++;
                if (wr_cyc < 0) begin wr_cyc = k; wr_a = bus.rf_wr_addr; wr_d = bus.rf_wr_data; end
            end
            if (bus.done !== bus.rf_wr_en) n_dn_bad++;
            if (!bus.req_ready) n_rdy_lo++;
            if (k == 1) rd_a = bus.rf_rd_addr;
            if (k < lat) drive_junk();
            else bus.req_valid = 1'b0;
        end
        chk("wr_latency", 32'(wr_cyc), 32'(lat));
        chk("wr_addr", 32'(wr_a), 32'(dst));
        chk("wr_data", 32'(wr_d), 32'(exp));
        chk("wr_pulses", 32'(n_wr), 32'd1);
        chk("bm_e_pulses", 32'(n_bm), 32'd1);
        chk("bm_e_cycle", 32'(e_cyc), 32'(lat - BM_LAT - 1));
        chk("bm_dst_in", 32'(bm_in_s), 32'(old));
        chk("bm_op", 32'(bm_op_s), 32'(op));
        chk("bm_byte", 32'(bm_b_s), 32'(b));
        chk("done_eq_wr", 32'(n_dn_bad), 32'd0);
        chk("ready_low_cycles", 32'(n_rdy_lo), 32'(lat));
        if (!hit) chk("rd_addr", 32'(rd_a), 32'(dst));
        m_rf[dst] = exp;
        m_lw_vld  = 1'b1;
        m_lw_addr = dst;
    endtask

    task automatic ill(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] b);
        chk("ill_ready_pre", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_dst = dst; bus.req_byte = b;
        @(negedge clk);
        chk("ill_err", 32'(bus.err), 32'd1);
        chk("ill_ready", 32'(bus.req_ready), 32'd1);
        chk("ill_bm_e", 32'(bus.bm_E), 32'd0);
        chk("ill_wr_en", 32'(bus.rf_wr_en), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ill_err_pulse", 32'(bus.err), 32'd0);
        chk("ill_wr_en2", 32'(bus.rf_wr_en), 32'd0);
    endtask

    // start a legal op, then reset in cycle at_k after the handshake
    task automatic rst_abort(input int at_k, input logic [2:0] dst);
        int lat, n_wr;
        lat = (FWD && m_lw_vld && m_lw_addr == dst) ? 2 + BM_LAT : 3 + BM_LAT;
        if (at_k > lat) at_k = lat;
        n_wr = 0;
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_dst = dst; bus.req_byte = 8'($urandom);
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            if (k < at_k) begin
                if (bus.rf_wr_en || bus.done) n_wr++;
                drive_junk();
            end
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        if (bus.rf_wr_en || bus.done) n_wr++;
        @(negedge clk);
        if (bus.rf_wr_en || bus.done) n_wr++;
        chk("rst_no_write", 32'(n_wr), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_bm_e", 32'(bus.bm_E), 32'd0);
        chk("rst_wr_data", 32'(bus.rf_wr_data), 32'd0);
        chk("rst_rf_kept", 32'(rf[dst]), 32'(m_rf[dst]));
        rst_n = 1'b1;
        m_lw_vld = 1'b0;
    endtask

    initial begin
        logic [2:0] op;
        logic [2:0] dst;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_dst = '0; bus.req_byte = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 3'(i);
            ld_data = (i == 2) ? 16'h1234 : 16'($urandom);
            m_rf[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_bm_e", 32'(bus.bm_E), 32'd0);
        chk("reset_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_wr_data", 32'(bus.rf_wr_data), 32'd0);
        chk("reset_bm_dst_in", 32'(bus.bm_dst_in), 32'd0);
        chk("reset_rd_addr", 32'(bus.rf_rd_addr), 32'd0);

        txn(3'd0, 3'd2, 8'hAB);
        ill(3'd6, 3'd3, 8'h55);
        txn(3'd4, 3'd5, 8'($urandom));
        txn(3'd3, 3'd1, 8'($urandom));
        txn(3'd1, 3'd1, 8'($urandom));
        rst_abort(2 + BM_LAT, 3'd4);
        rst_abort(3 + BM_LAT, 3'd6);

        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 3));
            if (op > 3'd4) ill(op, dst, 8'($urandom));
            else if ($urandom_range(0, 15) == 0) rst_abort($urandom_range(1, 3 + BM_LAT), dst);
            else txn(op, dst, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/byte_op_ctrl.md
BYTE_OP_CTRL -- requirements
Module: byte_op_ctrl

Interface
REQ-001 SHALL have parameter BM_LAT, default 1, meaning byte-manipulation unit cycles from bm_E rising to bm_dst_out valid (1..7).
REQ-002 SHALL have parameter RA_W, default 3, meaning register-file address width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_op  in  3  0 MOVL, 1 MOVLZ, 2 MOVLS, 3 MOVH, 4 SWPB, 5-7 illegal.
REQ-009 req_dst  in  RA_W  destination register.
REQ-010 req_byte  in  8  immediate byte.
REQ-011 rf_rd_addr  out  RA_W  register-file read address; read data combinational.
REQ-012 rf_rd_data  in  16  register-file read data.
REQ-013 bm_op / bm_byte / bm_dst_in  out  3/8/16  operands to byte-manipulation unit.
REQ-014 bm_E  out  1  execute strobe to byte-manipulation unit.
REQ-015 bm_dst_out  in  16  result from byte-manipulation unit.
REQ-016 rf_wr_en / rf_wr_addr / rf_wr_data  out  1/RA_W/16  register write-back.
REQ-017 done  out  1  one-cycle pulse on completed write-back.
REQ-018 err  out  1  one-cycle pulse on rejected illegal op.

Function
REQ-019 FSM states SHALL be IDLE, READ, EXEC, WAIT, WRITE.
REQ-020 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready at a rising edge.
REQ-021 On handshake SHALL latch req_op, req_dst, req_byte; legal op -> READ; illegal op -> stay IDLE, err=1 next cycle, no read, no write.
REQ-022 READ (1 cycle): rf_rd_addr = latched dst; capture rf_rd_data into operand register; -> EXEC.
REQ-023 EXEC (1 cycle): bm_E=1, bm_op/bm_byte/bm_dst_in driven from latched values and stable through WAIT; -> WAIT.
REQ-024 WAIT: bm_E=0; count BM_LAT-1 cycles (zero cycles when BM_LAT=1); -> WRITE.
REQ-025 WRITE (1 cycle): rf_wr_en=1, rf_wr_addr=latched dst, rf_wr_data=bm_dst_out, done=1; -> IDLE.
REQ-026 Handshake-to-write latency SHALL be 3+BM_LAT cycles (4 at default); next accept earliest the cycle after WRITE.
REQ-027 bm_E, rf_wr_en, done, err SHALL never be high for more than one consecutive cycle.
REQ-028 req_valid deasserting or changing while not in IDLE SHALL have no effect.
REQ-029 Outside their active states bm_E=0, rf_wr_en=0, done=0, err=0; data outputs hold last value.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, req_ready=1 after release, bm_E=0, rf_wr_en=0, done=0, err=0, all data outputs and latches 0, WAIT counter 0.
REQ-031 Reset mid-operation SHALL abort with no write-back and no done pulse, including when asserted in WRITE (rf_wr_en low that cycle).

Configuration
REQ-032 Macro BYTE_OP_CTRL_FWD_EN SHALL, when defined, add a last-write register (addr, data, valid); a legal request whose dst equals the valid last address SHALL skip READ, use the held data as bm_dst_in, latency 2+BM_LAT; valid cleared by reset.
REQ-033 Without BYTE_OP_CTRL_FWD_EN every legal request SHALL pass through READ; latency 3+BM_LAT.

Verification
REQ-034 Reset, then MOVL dst=2 byte=0xAB, R2=0x1234, BM_LAT=1 -> bm_E one pulse, rf_wr_en at cycle 4 with addr 2, data = bm_dst_out, done one pulse.
REQ-035 req_op=6 -> err pulse next cycle, no bm_E, no rf_wr_en, req_ready stays 1.
REQ-036 BM_LAT=3, SWPB dst=5 -> write-back at cycle 6, req_ready low cycles 1-6.
REQ-037 rst_n low during WAIT and separately during WRITE -> no rf_wr_en, no done, IDLE next cycle.
REQ-038 FWD_EN: MOVH dst=1 then MOVLZ dst=1 back-to-back -> second request has no READ, bm_dst_in = first result, latency 3; FWD off -> latency 4.
